data_mem_ext: RTL and testbench
===============================

DATA_MEM_EXT -- requirements
Module: data_mem_ext

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; depth = 2**ADDR_W 32-bit words.
REQ-002 SHALL have parameter LAT, default 2, access latency in cycles from accept to response; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  1  access request, sampled only while ready=1.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr  input  ADDR_W+2  byte address.
REQ-008 SHALL have port size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 SHALL have port sext  input  1  load sign-extension enable for byte and half loads.
REQ-010 SHALL have port wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port ready  output  1  block can accept a request this cycle.
REQ-012 SHALL have port rvalid  output  1  one-cycle response strobe.
REQ-013 SHALL have port rdata  output  32  load result, valid with rvalid.
REQ-014 SHALL have port err  output  1  misaligned or illegal-size flag, valid with rvalid.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and RESP; ready SHALL be 1 only in IDLE.
REQ-016 SHALL transition IDLE->BUSY on req=1, registering we, addr, size, sext and wdata; other inputs are ignored outside IDLE.
REQ-017 SHALL load a down-counter with LAT-1 on accept, hold BUSY while it is nonzero, then go to RESP.
REQ-018 SHALL assert rvalid for exactly one cycle in RESP, then return to IDLE; a new request is accepted no earlier than the following cycle, giving accept-to-rvalid = LAT cycles and throughput of one access per LAT+1 cycles.
REQ-019 SHALL detect misalignment (half with addr[0]=1, word with addr[1:0]!=0, size=11) at accept; such accesses SHALL not modify memory and SHALL respond with err=1 and rdata=0.
REQ-020 SHALL commit stores only on the BUSY->RESP edge, writing only the addressed byte lanes: byte lane addr[1:0]; half lanes {addr[1],0} and {addr[1],1}; word all four lanes (little-endian).
REQ-021 SHALL form load data from the word read at the addressed word: select the lane(s), then zero- or sign-extend to 32 bits per sext; word loads ignore sext.
REQ-022 SHALL hold rdata registered and stable from RESP until the next rvalid; stores SHALL return rdata=0 and err=0 when aligned.
REQ-023 SHALL wrap no addresses: every addr value maps to word addr[ADDR_W+1:2].
REQ-024 SHALL keep rvalid, err and ready mutually consistent: rvalid=1 implies ready=0.

Reset
REQ-025 SHALL, on rst_n=0 at any time, force IDLE, counter=0, ready=1 (after release), rvalid=0, err=0 and rdata=0 asynchronously.
REQ-026 SHALL abort an in-flight access on reset; a store not yet committed (REQ-020) SHALL leave memory unchanged.
REQ-027 SHALL not reset memory array contents.

Structure
REQ-028 SHALL take the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings from the shared definitions package used by the CPU.
REQ-029 SHALL isolate the lane-select/extension logic in one combinational sub-module, load_align.

Verification
REQ-030 SHALL cover: LAT=2, store word 0x12345678 at addr 0x010 then load word at 0x010 -> rvalid exactly 2 cycles after each accept, rdata=0x12345678.
REQ-031 SHALL cover: sb 0xAB at 0x011 over word 0x12345678, then lb sext=1 at 0x011 -> rdata=0xFFFFFFAB; reloading the word returns 0x1234AB78.
REQ-032 SHALL cover: lh sext=0 at 0x012 of word 0x8001ABCD -> rdata=0x00008001; with sext=1 -> rdata=0xFFFF8001.
REQ-033 SHALL cover: sw at 0x013 -> err=1, rdata=0, memory word unchanged on reload.
REQ-034 SHALL cover: rst_n pulsed low one cycle after accepting sw 0xDEADBEEF with LAT=3 -> rvalid never asserts, ready=1 after release, and a reload returns the old contents.
REQ-035 SHALL cover: req held high continuously for 4 loads -> exactly 4 accepts, one per LAT+1 cycles, each matching its rvalid.

Source files
------------

// File: rtl/data_mem_ext_pkg.sv
// Shared definitions for the data memory: access-size encodings, FSM states
// and small address/lane helpers.
package data_mem_ext_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Byte lanes touched by an access (little-endian).
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across lanes so any lane can pick it up.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ext_load_align.sv
// Load lane select and zero/sign extension of a memory word.
module load_align
  import data_mem_ext_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    b    = word[7:0];
    h    = lane[1] ? word[31:16] : word[15:0];
    data = '0;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    case (size)
      SZ_BYTE: data = {{24{sext & b[7]}}, b};
      SZ_HALF: data = {{16{sext & h[15]}}, h};
      SZ_WORD: data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ext.sv
// Fixed-latency byte-addressed data memory with byte/half/word access,
// alignment checking and a one-cycle response strobe.
module data_mem_ext
  import data_mem_ext_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W+1:0] addr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  // With LAT=1 there is no BUSY cycle: the accept edge is also the commit edge.
  localparam bit         DIRECT   = (LAT == 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q, sext_q, err_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [2**ADDR_W];

  logic              accept, go_resp;
  logic              a_we, a_sext, a_err;
  logic [ADDR_W+1:0] a_addr;
  logic [1:0]        a_size;
  logic [31:0]       a_wdata;
  logic [ADDR_W-1:0] waddr;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       ld_data;

  assign accept  = (state == IDLE) && req;
  assign go_resp = rst_n && ((DIRECT && accept) || ((state == BUSY) && (cnt <= 4'd1)));

  // Access fields: live inputs on the accept cycle, captured copies afterwards.
  always_comb begin
    a_we    = we_q;
    a_addr  = addr_q;
    a_size  = size_q;
    a_sext  = sext_q;
    a_wdata = wdata_q;
    a_err   = err_q;
    if (state == IDLE) begin
      a_we    = we;
      a_addr  = addr;
      a_size  = size;
      a_sext  = sext;
      a_wdata = wdata;
      a_err   = misaligned(size, addr[1:0]);
    end
  end

  assign waddr  = a_addr[ADDR_W+1:2];
  assign be     = lane_mask(a_size, a_addr[1:0]);
  assign wlanes = store_lanes(a_size, a_wdata);

  load_align u_align (
    .word (mem[waddr]),
    .lane (a_addr[1:0]),
    .size (a_size),
    .sext (a_sext),
    .data (ld_data)
  );

  // Control FSM with registered ready/rvalid/err/rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ready   <= 1'b1;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            size_q  <= size;
            sext_q  <= sext;
            wdata_q <= wdata;
            err_q   <= misaligned(size, addr[1:0]);
            cnt     <= CNT_INIT;
            ready   <= 1'b0;
            state   <= DIRECT ? RESP : BUSY;
          end
        end
        BUSY: begin
          // Leave on the cycle whose decrement reaches zero.
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
      if (go_resp) begin
        rvalid <= 1'b1;
        err    <= a_err;
        rdata  <= (a_err || a_we) ? '0 : ld_data;
      end
    end
  end

  // Store commit on entry to RESP, addressed lanes only; array is never reset.
  always_ff @(posedge clk) begin
    if (go_resp && a_we && !a_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ext.sv
// Scoreboard bench for data_mem_ext: LAT=2 instance for functional traffic,
// LAT=3 instance for the reset-abort scenario.
module tb_data_mem_ext;

  localparam int unsigned LAT = 2;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, we, sext, ready, rvalid, err;
  logic [11:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata, rdata;

  logic        rst_n3, req3, we3, sext3, ready3, rvalid3, err3;
  logic [11:0] addr3;
  logic [1:0]  size3;
  logic [31:0] wdata3, rdata3;

  data_mem_ext #(.ADDR_W(10), .LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .size(size),
    .sext(sext), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  data_mem_ext #(.ADDR_W(10), .LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .req(req3), .we(we3), .addr(addr3), .size(size3),
    .sext(sext3), .wdata(wdata3), .ready(ready3), .rvalid(rvalid3), .rdata(rdata3), .err(err3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned vecs = 0;
  int unsigned errs = 0;
  int unsigned nresp = 0;
  int unsigned cyc = 0;
  bit [31:0]   model [int];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit tb_mis(input logic [11:0] a, input logic [1:0] sz);
    return (sz == X) || (sz == H && a[0]) || (sz == W && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mload(input bit [31:0] w, input logic [1:0] a,
                                        input logic [1:0] sz, input logic sx);
    bit [31:0] s;
    s = w >> (8 * a);
    if (sz == B) return (sx && s[7]) ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
    if (sz == H) return (sx && s[15]) ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
    return w;
  endfunction

  function automatic bit [31:0] mstore(input bit [31:0] w, input logic [1:0] a,
                                       input logic [1:0] sz, input logic [31:0] wd);
    bit [31:0] m, d;
    if (sz == B) begin m = 32'hFF << (8 * a); d = (wd & 32'hFF) << (8 * a); end
    else if (sz == H) begin m = 32'hFFFF << (8 * a); d = (wd & 32'hFFFF) << (8 * a); end
    else begin m = '1; d = wd; end
    return (w & ~m) | (d & m);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rvalid) begin
        vecs++;
        if (ready !== 1'b0) begin
          errs++;
          $display("FAIL ready_during_rvalid: ready=%b required 0", ready);
        end
        vecs++;
        if (sbq.size() == 0) begin
          errs++;
          $display("FAIL spurious_rvalid: rvalid=1 with no access outstanding");
        end else begin
          e = sbq.pop_front();
          nresp++;
          vecs++;
          if (rdata !== e.rdata) begin
            errs++;
            $display("FAIL rdata: got %h required %h", rdata, e.rdata);
          end
          vecs++;
          if (err !== e.err) begin
            errs++;
            $display("FAIL err: got %b required %b", err, e.err);
          end
          vecs++;
          if (cyc - e.cyc !== LAT) begin
            errs++;
            $display("FAIL latency: got %0d required %0d", cyc - e.cyc, LAT);
          end
        end
      end
    end
  endtask

  task automatic access(input logic w, input logic [11:0] a, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
    int unsigned n;
    exp_t        e;
    n = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; size = sz; sext = sx; wdata = wd;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    vecs++;
    if (!ready) begin
      errs++;
      $display("FAIL accept_timeout: ready=%b required 1", ready);
    end else begin
      e.rdata = er; e.err = ee; e.cyc = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic maccess(input logic w, input logic [11:0] a, input logic [1:0] sz,
                         input logic sx, input logic [31:0] wd);
    int          k;
    logic [31:0] er;
    logic        ee;
    k  = int'(a >> 2);
    ee = tb_mis(a, sz);
    er = '0;
    if (!ee) begin
      if (w) model[k] = mstore(model.exists(k) ? model[k] : 32'h0, a[1:0], sz, wd);
      else   er = mload(model[k], a[1:0], sz, sx);
    end
    access(w, a, sz, sx, wd, er, ee);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
    vecs++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n3 = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid: got %b required 0", rvalid); end
    vecs++;
    if (err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b required 0", err); end
    vecs++;
    if (rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    rst_n = 1'b1; rst_n3 = 1'b1;
    @(negedge clk);
    vecs++;
    if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b required 1", ready); end
  endtask

  task automatic test_word();
    access(1'b1, 12'h010, W, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
    access(1'b0, 12'h010, W, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
    drain();
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if (rdata !== 32'h1234_5678) begin
        errs++;
        $display("FAIL rdata_hold: got %h required 12345678", rdata);
      end
    end
  endtask

  task automatic test_byte();
    access(1'b1, 12'h011, B, 1'b0, 32'h0000_00AB, 32'h0, 1'b0);
    access(1'b0, 12'h011, B, 1'b1, 32'h0, 32'hFFFF_FFAB, 1'b0);
    access(1'b0, 12'h011, B, 1'b0, 32'h0, 32'h0000_00AB, 1'b0);
    access(1'b0, 12'h010, W, 1'b1, 32'h0, 32'h1234_AB78, 1'b0);
    drain();
  endtask

  task automatic test_half();
    access(1'b1, 12'h010, W, 1'b0, 32'h8001_ABCD, 32'h0, 1'b0);
    access(1'b0, 12'h012, H, 1'b0, 32'h0, 32'h0000_8001, 1'b0);
    access(1'b0, 12'h012, H, 1'b1, 32'h0, 32'hFFFF_8001, 1'b0);
    access(1'b0, 12'h010, H, 1'b1, 32'h0, 32'hFFFF_ABCD, 1'b0);
    access(1'b0, 12'h013, B, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
    access(1'b1, 12'h012, H, 1'b0, 32'hFFFF_5555, 32'h0, 1'b0);
    access(1'b0, 12'h010, W, 1'b0, 32'h0, 32'h5555_ABCD, 1'b0);
    drain();
  endtask

  task automatic test_misalign();
    access(1'b1, 12'h013, W, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1);
    access(1'b0, 12'h010, W, 1'b0, 32'h0, 32'h5555_ABCD, 1'b0);
    access(1'b0, 12'h011, H, 1'b1, 32'h0, 32'h0, 1'b1);
    access(1'b0, 12'h010, X, 1'b0, 32'h0, 32'h0, 1'b1);
    access(1'b1, 12'h013, H, 1'b0, 32'h0000_1111, 32'h0, 1'b1);
    access(1'b1, 12'h012, W, 1'b0, 32'h2222_2222, 32'h0, 1'b1);
    access(1'b1, 12'h010, X, 1'b0, 32'h3333_3333, 32'h0, 1'b1);
    access(1'b0, 12'h010, W, 1'b0, 32'h0, 32'h5555_ABCD, 1'b0);
    access(1'b1, 12'hFFC, W, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
    access(1'b0, 12'hFFC, W, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
    access(1'b0, 12'hFFF, B, 1'b0, 32'h0, 32'h0000_00CA, 1'b0);
    access(1'b0, 12'hFFE, H, 1'b1, 32'h0, 32'hFFFF_CAFE, 1'b0);
    access(1'b0, 12'h010, W, 1'b0, 32'h0, 32'h5555_ABCD, 1'b0);
    drain();
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int i = 0; i < 4; i++)
      maccess(1'b1, 12'h100 + 12'(4 * i), W, 1'b0, $urandom);
    for (int i = 0; i < 24; i++) begin
      a = 12'h100 + 12'($urandom_range(0, 15));
      maccess(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int unsigned acc[4];
    int unsigned r0, n;
    exp_t        e;
    r0 = nresp;
    @(negedge clk);
    req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      we = 1'b0; addr = 12'h100 + 12'(4 * k); size = W; sext = 1'b0; wdata = '0;
      n = 0;
      while (!ready && n < 50) begin @(negedge clk); n++; end
      vecs++;
      if (!ready) begin
        errs++;
        $display("FAIL b2b_accept_timeout: ready=%b required 1", ready);
      end else begin
        e.rdata = model[int'(addr >> 2)]; e.err = 1'b0; e.cyc = cyc;
        sbq.push_back(e);
      end
      acc[k] = cyc;
      @(negedge clk);
    end
    req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      vecs++;
      if (acc[k] - acc[k-1] !== LAT + 1) begin
        errs++;
        $display("FAIL b2b_spacing: got %0d required %0d", acc[k] - acc[k-1], LAT + 1);
      end
    end
    drain();
    repeat (4) @(negedge clk);
    vecs++;
    if (nresp - r0 !== 4) begin
      errs++;
      $display("FAIL b2b_count: got %0d responses required 4", nresp - r0);
    end
  endtask

  task automatic acc3(input logic w, input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic ee, output int unsigned lat);
    int unsigned n, t0;
    n = 0;
    @(negedge clk);
    req3 = 1'b1; we3 = w; addr3 = a; size3 = W; sext3 = 1'b0; wdata3 = wd;
    while (!ready3 && n < 50) begin @(negedge clk); n++; end
    t0 = cyc;
    @(negedge clk);
    req3 = 1'b0;
    n = 0;
    while (!rvalid3 && n < 50) begin @(negedge clk); n++; end
    lat = rvalid3 ? cyc - t0 : 0;
    rd  = rdata3;
    ee  = err3;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        ee;
    int unsigned lat, seen;
    acc3(1'b1, 12'h020, 32'h1111_2222, rd, ee, lat);
    vecs++;
    if (lat !== 3) begin errs++; $display("FAIL l3_store_latency: got %0d required 3", lat); end
    vecs++;
    if (ee !== 1'b0) begin errs++; $display("FAIL l3_store_err: got %b required 0", ee); end
    acc3(1'b0, 12'h020, 32'h0, rd, ee, lat);
    vecs++;
    if (rd !== 32'h1111_2222) begin errs++; $display("FAIL l3_load: got %h required 11112222", rd); end
    vecs++;
    if (lat !== 3) begin errs++; $display("FAIL l3_load_latency: got %0d required 3", lat); end

    @(negedge clk);
    req3 = 1'b1; we3 = 1'b1; addr3 = 12'h020; size3 = W; wdata3 = 32'hDEAD_BEEF;
    vecs++;
    if (ready3 !== 1'b1) begin errs++; $display("FAIL l3_ready_before_abort: got %b required 1", ready3); end
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    rst_n3 = 1'b0;
    #1;
    vecs++;
    if (rdata3 !== 32'h0) begin errs++; $display("FAIL async_rdata: got %h required 0", rdata3); end
    vecs++;
    if (rvalid3 !== 1'b0 || err3 !== 1'b0) begin
      errs++;
      $display("FAIL async_flags: rvalid=%b err=%b required 0 0", rvalid3, err3);
    end
    @(negedge clk);
    rst_n3 = 1'b1;
    #1;
    vecs++;
    if (ready3 !== 1'b1) begin errs++; $display("FAIL abort_ready: got %b required 1", ready3); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid3) seen++;
    end
    vecs++;
    if (seen !== 0) begin errs++; $display("FAIL abort_rvalid: got %0d strobes required 0", seen); end
    acc3(1'b0, 12'h020, 32'h0, rd, ee, lat);
    vecs++;
    if (rd !== 32'h1111_2222) begin errs++; $display("FAIL abort_reload: got %h required 11112222", rd); end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = '0; size = W; sext = 1'b0; wdata = '0;
    req3 = 1'b0; we3 = 1'b0; addr3 = '0; size3 = W; sext3 = 1'b0; wdata3 = '0;
    rst_n = 1'b0; rst_n3 = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog timeout");
  end

endmodule
